// File: rtl/uart_cmd_sequencer.sv
// rtl/uart_cmd_sequencer.sv - UART host packet framer: buffer writes, EXEC issue, ACK/NAK response
module uart_cmd_sequencer #(
  parameter int unsigned CLOCK_FREQ   = 100_000_000,
  parameter int unsigned TIMEOUT_CLKS = CLOCK_FREQ / 100,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned ADDR_W       = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  output logic [7:0]        tx_data,
  output logic              tx_start,
  input  logic              tx_busy,
  output logic              busy,
  output logic              err_timeout,
  output logic              err_overrun
);

  localparam logic [7:0] OPC_WRITE = 8'h01;
  localparam logic [7:0] OPC_EXEC  = 8'h02;
  localparam logic [7:0] RESP_ACK  = 8'h06;
  localparam logic [7:0] RESP_NAK  = 8'h15;

  // One spare bit so TIMEOUT_CLKS-1 always fits, even for powers of two.
  localparam int unsigned     TO_W    = $clog2(TIMEOUT_CLKS) + 1;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CLKS - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_OPC,
    S_ADDR_H,
    S_ADDR_L,
    S_LEN,
    S_PAYLOAD,
    S_CSUM,
    S_ISSUE,
    S_RESP
  } state_t;

  state_t            state_q;
  state_t            state_d;

  logic [7:0]        opc_q;
  logic [7:0]        addr_hi_q;
  logic [ADDR_W-1:0] addr_q;
  logic [7:0]        len_q;
  logic [7:0]        idx_q;
  logic [7:0]        csum_q;
  logic [TO_W-1:0]   to_cnt_q;
  logic [7:0]        tx_data_q;
  logic              wr_en_q;
  logic [ADDR_W-1:0] wr_addr_q;
  logic [7:0]        wr_data_q;
  logic              err_timeout_q;
  logic              err_overrun_q;

  logic              in_frame;
  logic              expire;
  logic              csum_ok;
  logic              resp_load;
  logic [7:0]        resp_val;

  // The inter-byte watchdog only runs while a packet is being received.
  assign in_frame = (state_q == S_OPC)    || (state_q == S_ADDR_H) ||
                    (state_q == S_ADDR_L) || (state_q == S_LEN)    ||
                    (state_q == S_PAYLOAD) || (state_q == S_CSUM);

  assign csum_ok = (rx_data == csum_q);

  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign cmd_addr    = addr_q;
  assign cmd_len     = len_q;
  assign tx_data     = tx_data_q;
  assign err_timeout = err_timeout_q;
  assign err_overrun = err_overrun_q;

  // Next-state, handshake outputs and response selection.
  always_comb begin
    state_d   = state_q;
    cmd_valid = 1'b0;
    tx_start  = 1'b0;
    resp_load = 1'b0;
    resp_val  = RESP_NAK;
    busy      = (state_q != S_IDLE);
    // A byte arriving on the expiry cycle takes precedence over the abort.
    expire    = in_frame && !rx_valid && (to_cnt_q == TO_LAST);

    case (state_q)
      S_IDLE: begin
        if (rx_valid && (rx_data == SYNC_BYTE)) state_d = S_OPC;
      end
      S_OPC: begin
        if (rx_valid) state_d = S_ADDR_H;
      end
      S_ADDR_H: begin
        if (rx_valid) state_d = S_ADDR_L;
      end
      S_ADDR_L: begin
        if (rx_valid) state_d = S_LEN;
      end
      S_LEN: begin
        if (rx_valid) state_d = (rx_data == 8'd0) ? S_CSUM : S_PAYLOAD;
      end
      S_PAYLOAD: begin
        if (rx_valid && (idx_q == (len_q - 8'd1))) state_d = S_CSUM;
      end
      S_CSUM: begin
        if (rx_valid) begin
          if (csum_ok && (opc_q == OPC_EXEC)) begin
            state_d = S_ISSUE;
          end else begin
            state_d   = S_RESP;
            resp_load = 1'b1;
            resp_val  = (csum_ok && (opc_q == OPC_WRITE)) ? RESP_ACK : RESP_NAK;
          end
        end
      end
      S_ISSUE: begin
        cmd_valid = 1'b1;
        if (cmd_ready) begin
          state_d   = S_RESP;
          resp_load = 1'b1;
          resp_val  = RESP_ACK;
        end
      end
      S_RESP: begin
        if (!tx_busy) begin
          tx_start = 1'b1;
          state_d  = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (expire) state_d = S_IDLE;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Inter-byte idle counter: restarts on every received byte and outside a frame.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_cnt_q <= '0;
    end else if (rx_valid || !in_frame) begin
      to_cnt_q <= '0;
    end else begin
      to_cnt_q <= to_cnt_q + TO_W'(1);
    end
  end

  // Header capture, payload index and running checksum (OPC through last payload byte).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opc_q     <= '0;
      addr_hi_q <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      csum_q    <= '0;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE: begin
          idx_q  <= '0;
          csum_q <= '0;
        end
        S_OPC: begin
          opc_q  <= rx_data;
          csum_q <= rx_data;
        end
        S_ADDR_H: begin
          addr_hi_q <= rx_data;
          csum_q    <= csum_q ^ rx_data;
        end
        S_ADDR_L: begin
          addr_q <= ADDR_W'({addr_hi_q, rx_data});
          csum_q <= csum_q ^ rx_data;
        end
        S_LEN: begin
          len_q  <= rx_data;
          idx_q  <= '0;
          csum_q <= csum_q ^ rx_data;
        end
        S_PAYLOAD: begin
          idx_q  <= idx_q + 8'd1;
          csum_q <= csum_q ^ rx_data;
        end
        default: begin
        end
      endcase
    end
  end

  // Buffer write port: one strobe per WRITE payload byte, address wraps at 2^ADDR_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      wr_en_q <= 1'b0;
      if (rx_valid && (state_q == S_PAYLOAD) && (opc_q == OPC_WRITE)) begin
        wr_en_q   <= 1'b1;
        wr_addr_q <= addr_q + ADDR_W'(idx_q);
        wr_data_q <= rx_data;
      end
    end
  end

  // Response byte, latched on entry to RESP and held until the next response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data_q <= '0;
    end else if (resp_load) begin
      tx_data_q <= resp_val;
    end
  end

  // Error pulses: timeout abort and bytes dropped while issuing or responding.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_timeout_q <= 1'b0;
      err_overrun_q <= 1'b0;
    end else begin
      err_timeout_q <= expire;
      err_overrun_q <= rx_valid && ((state_q == S_ISSUE) || (state_q == S_RESP));
    end
  end

endmodule
